// File: rtl/if_fetch_queue_if.sv
// Handshake bundle for if_fetch_queue: split-transaction instruction SRAM bus,
// redirect inputs and the valid/ready queue output toward ID.
interface if_fetch_queue_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        ex_flush;
   logic [31:0] ex_entry;
   logic        br_taken;
   logic [31:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        has_exception_out;
   logic [5:0]  ecode_out;
   logic [8:0]  esubcode_out;

   modport master (
      output inst_req, inst_addr, out_valid, out_pc, out_inst,
             has_exception_out, ecode_out, esubcode_out,
      input  inst_addr_ok, inst_data_ok, inst_rdata, ex_flush, ex_entry,
             br_taken, br_target, out_ready
   );

   modport slave (
      input  inst_req, inst_addr, out_valid, out_pc, out_inst,
             has_exception_out, ecode_out, esubcode_out,
      output inst_addr_ok, inst_data_ok, inst_rdata, ex_flush, ex_entry,
             br_taken, br_target, out_ready
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage with outstanding-request tracking and an instruction queue toward ID.
// Optional macro IF_BYPASS_EN: zero-latency path from data_ok to out_* when the queue is empty.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input logic               clk,
   input logic               rst,
   if_fetch_queue_if.master  bus
);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;
   localparam logic [FW:0] DEPTH_CNT  = (FW+1)'(FIFO_DEPTH);
   localparam logic [5:0]  ECODE_ADEF = 6'h08;

   logic [31:0]   fetch_pc;
   logic          adef_sent;
   logic [OW-1:0] outstanding, discard, outstanding_nx;
   logic [31:0]   pend_pc [MAX_OUTSTANDING];
   logic [PW-1:0] pend_wr, pend_rd;
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [31:0]   fifo_inst [FIFO_DEPTH];
   logic          fifo_exc  [FIFO_DEPTH];
   logic [FW-1:0] fifo_wr, fifo_rd;
   logic [FW:0]   fifo_count;

   logic          redirect, aligned, credit, fire, rsp_ok, rsp_live, adef_enq;
   logic          fifo_empty, fifo_full, enq, deq, bypass_show, bypass_take;
   logic [31:0]   target, enq_pc, enq_inst, head_pc, head_inst;
   logic          enq_exc, head_exc;
   logic [CW-1:0] live;

   function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   assign redirect = bus.ex_flush | bus.br_taken;
   assign target   = bus.ex_flush ? bus.ex_entry : bus.br_target;
   assign aligned  = (fetch_pc[1:0] == 2'b00);
   assign live     = CW'(outstanding) - CW'(discard);
   // Space is reserved for every live request, so a returning response always fits.
   assign credit   = ((live + CW'(fifo_count)) < CW'(FIFO_DEPTH)) &&
                     (outstanding < OW'(MAX_OUTSTANDING));

   assign bus.inst_req  = !rst & !redirect & aligned & credit;
   assign bus.inst_addr = {fetch_pc[31:2], 2'b00};
   assign fire          = bus.inst_req & bus.inst_addr_ok;

   assign rsp_ok     = bus.inst_data_ok & (outstanding != '0);
   assign rsp_live   = rsp_ok & (discard == '0) & !redirect & !rst;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == DEPTH_CNT);
   assign adef_enq   = !rst & !redirect & !aligned & (live == '0) & !fifo_full & !adef_sent;

`ifdef IF_BYPASS_EN
   assign bypass_show = rsp_live & fifo_empty;
`else
   assign bypass_show = 1'b0;
`endif
   assign bypass_take = bypass_show & bus.out_ready;
   assign enq = (rsp_live & !bypass_take) | adef_enq;
   assign deq = !rst & !redirect & !fifo_empty & bus.out_ready;

   always_comb begin
      enq_pc   = fetch_pc;
      enq_inst = 32'h0;
      enq_exc  = 1'b1;
      if (rsp_live) begin
         enq_pc   = pend_pc[pend_rd];
         enq_inst = bus.inst_rdata;
         enq_exc  = 1'b0;
      end
   end

   always_comb begin
      head_pc   = fifo_pc[fifo_rd];
      head_inst = fifo_inst[fifo_rd];
      head_exc  = fifo_exc[fifo_rd];
      if (bypass_show) begin
         head_pc   = pend_pc[pend_rd];
         head_inst = bus.inst_rdata;
         head_exc  = 1'b0;
      end
   end

   assign bus.out_valid         = !rst & !redirect & (!fifo_empty | bypass_show);
   assign bus.out_pc            = head_pc;
   assign bus.out_inst          = head_inst;
   assign bus.has_exception_out = head_exc;
   assign bus.ecode_out         = head_exc ? ECODE_ADEF : 6'h00;
   assign bus.esubcode_out      = 9'h000;

   always_comb begin
      outstanding_nx = outstanding;
      if (fire && !rsp_ok)
         outstanding_nx = outstanding + OW'(1);
      else if (!fire && rsp_ok)
         outstanding_nx = outstanding - OW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         adef_sent   <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         pend_wr     <= '0;
         pend_rd     <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         fifo_count  <= '0;
      end else begin
         outstanding <= outstanding_nx;
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc   <= target;
            adef_sent  <= 1'b0;
            discard    <= outstanding_nx;
            pend_wr    <= '0;
            pend_rd    <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
         end else begin
            if (fire) begin
               fetch_pc <= fetch_pc + 32'd4;
               pend_wr  <= pend_inc(pend_wr);
            end
            if (rsp_ok && discard != '0)
               discard <= discard - OW'(1);
            if (rsp_live)
               pend_rd <= pend_inc(pend_rd);
            if (adef_enq)
               adef_sent <= 1'b1;
            if (enq)
               fifo_wr <= fifo_wr + FW'(1);
            if (deq)
               fifo_rd <= fifo_rd + FW'(1);
            case ({enq, deq})
               2'b10:   fifo_count <= fifo_count + (FW+1)'(1);
               2'b01:   fifo_count <= fifo_count - (FW+1)'(1);
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fire)
         pend_pc[pend_wr] <= fetch_pc;
      if (enq) begin
         fifo_pc[fifo_wr]   <= enq_pc;
         fifo_inst[fifo_wr] <= enq_inst;
         fifo_exc[fifo_wr]  <= enq_exc;
      end
   end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a simple in-order SRAM responder
// (data = addr ^ 32'h5a5a0000, one cycle after address acceptance).
module tb_if_fetch_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   if_fetch_queue_if bus ();
   if_fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic        rsp_en;
   logic [31:0] rsp_q[$];
   logic [31:0] req_log [64];
   logic [31:0] dv_pc   [64];
   logic [31:0] dv_inst [64];
   logic [31:0] dv_flag [64];
   int          n_req, n_dv, cyc, t_rsp, t_val;
   logic        s_req, s_valid;
   logic [31:0] s_pc;

`ifdef IF_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 64; i++) begin
         req_log[i] = 32'hffff_ffff;
         dv_pc[i]   = 32'hffff_ffff;
         dv_inst[i] = 32'hffff_ffff;
         dv_flag[i] = 32'hffff_ffff;
      end
      n_req = 0;
      n_dv  = 0;
      t_rsp = -1;
      t_val = -1;
   endtask

   task automatic step();
      logic        acc;
      logic [31:0] acc_addr;
      if (!rst && rsp_en && rsp_q.size() > 0) begin
         bus.inst_data_ok = 1'b1;
         bus.inst_rdata   = rsp_q[0] ^ 32'h5a5a0000;
      end else begin
         bus.inst_data_ok = 1'b0;
         bus.inst_rdata   = 32'h0;
      end
      #1;
      s_req    = bus.inst_req;
      s_valid  = bus.out_valid;
      s_pc     = bus.out_pc;
      acc      = bus.inst_req & bus.inst_addr_ok;
      acc_addr = bus.inst_addr;
      if (acc && n_req < 64) begin
         req_log[n_req] = acc_addr;
         n_req++;
      end
      if (bus.out_valid && bus.out_ready && n_dv < 64) begin
         dv_pc[n_dv]   = bus.out_pc;
         dv_inst[n_dv] = bus.out_inst;
         dv_flag[n_dv] = {16'h0, bus.has_exception_out, bus.ecode_out, bus.esubcode_out};
         n_dv++;
      end
      if (bus.inst_data_ok && t_rsp < 0) t_rsp = cyc;
      if (bus.out_valid && t_val < 0) t_val = cyc;
      @(posedge clk);
      if (rst) rsp_q.delete();
      else begin
         if (bus.inst_data_ok) void'(rsp_q.pop_front());
         if (acc) rsp_q.push_back(acc_addr);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      clear_logs();
   endtask

   initial begin
      bus.inst_addr_ok = 1'b1;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      bus.ex_flush     = 1'b0;
      bus.ex_entry     = 32'h0;
      bus.br_taken     = 1'b0;
      bus.br_target    = 32'h0;
      bus.out_ready    = 1'b1;
      rsp_en = 1'b1;
      cyc    = 0;
      clear_logs();

      // 1: streaming fetch after reset
      rst = 1'b1;
      step();
      check_val("rst_req", 32'(s_req), 32'd0);
      check_val("rst_valid", 32'(s_valid), 32'd0);
      do_reset();
      run(8);
      check_val("t1_req0", req_log[0], 32'h1c000000);
      check_val("t1_req1", req_log[1], 32'h1c000004);
      check_val("t1_req3", req_log[3], 32'h1c00000c);
      check_val("t1_pc0", dv_pc[0], 32'h1c000000);
      check_val("t1_pc1", dv_pc[1], 32'h1c000004);
      check_val("t1_pc3", dv_pc[3], 32'h1c00000c);
      check_val("t1_inst0", dv_inst[0], 32'h465a0000);
      check_val("t1_inst3", dv_inst[3], 32'h465a000c);
      check_val("t1_latency", 32'(t_val - t_rsp), 32'(LAT));

      // 2: back-pressure fills the queue without overflow
      do_reset();
      bus.out_ready = 1'b0;
      run(10);
      check_val("t2_nreq", 32'(n_req), 32'd4);
      check_val("t2_req_stall", 32'(s_req), 32'd0);
      check_val("t2_ndv_hold", 32'(n_dv), 32'd0);
      check_val("t2_head_valid", 32'(s_valid), 32'd1);
      check_val("t2_head_pc", s_pc, 32'h1c000000);
      bus.out_ready = 1'b1;
      run(8);
      check_val("t2_pc0", dv_pc[0], 32'h1c000000);
      check_val("t2_pc1", dv_pc[1], 32'h1c000004);
      check_val("t2_pc2", dv_pc[2], 32'h1c000008);
      check_val("t2_pc3", dv_pc[3], 32'h1c00000c);
      check_val("t2_pc4", dv_pc[4], 32'h1c000010);

      // 3: branch with two requests in flight
      do_reset();
      rsp_en = 1'b0;
      run(2);
      step();
      check_val("t3_cap_req", 32'(s_req), 32'd0);
      check_val("t3_nreq", 32'(n_req), 32'd2);
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h1c000100;
      step();
      check_val("t3_redir_req", 32'(s_req), 32'd0);
      bus.br_taken = 1'b0;
      rsp_en = 1'b1;
      clear_logs();
      run(8);
      check_val("t3_req0", req_log[0], 32'h1c000100);
      check_val("t3_pc0", dv_pc[0], 32'h1c000100);
      check_val("t3_inst0", dv_inst[0], 32'h465a0100);

      // 4: exception redirect beats branch redirect
      do_reset();
      run(2);
      bus.ex_flush  = 1'b1;
      bus.ex_entry  = 32'h1c008000;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h1c000200;
      step();
      check_val("t4_flush_valid", 32'(s_valid), 32'd0);
      bus.ex_flush = 1'b0;
      bus.br_taken = 1'b0;
      clear_logs();
      run(6);
      check_val("t4_req0", req_log[0], 32'h1c008000);
      check_val("t4_pc0", dv_pc[0], 32'h1c008000);

      // 5: misaligned target raises ADEF once, then idles
      do_reset();
      step();
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h1c000102;
      step();
      bus.br_taken = 1'b0;
      clear_logs();
      run(8);
      check_val("t5_nreq", 32'(n_req), 32'd0);
      check_val("t5_ndv", 32'(n_dv), 32'd1);
      check_val("t5_pc", dv_pc[0], 32'h1c000102);
      check_val("t5_inst", dv_inst[0], 32'h0);
      check_val("t5_flags", dv_flag[0], {16'h0, 1'b1, 6'h08, 9'h000});
      bus.ex_flush = 1'b1;
      bus.ex_entry = 32'h1c000000;
      step();
      bus.ex_flush = 1'b0;
      clear_logs();
      run(4);
      check_val("t5_resume", req_log[0], 32'h1c000000);

      // 6: reset with two outstanding and a non-empty queue
      do_reset();
      bus.out_ready = 1'b0;
      run(3);
      rsp_en = 1'b0;
      run(1);
      rst = 1'b1;
      step();
      check_val("t6_rst_req", 32'(s_req), 32'd0);
      check_val("t6_rst_valid", 32'(s_valid), 32'd0);
      rst = 1'b0;
      rsp_en = 1'b1;
      bus.out_ready = 1'b1;
      clear_logs();
      step();
      check_val("t6_post_valid", 32'(s_valid), 32'd0);
      run(6);
      check_val("t6_req0", req_log[0], 32'h1c000000);
      check_val("t6_pc0", dv_pc[0], 32'h1c000000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
